// File: rtl/imem_prog.sv
// imem_prog: run-time loadable instruction store for the lab CPU.
// A host streams words in through an auto-incrementing program port while in
// PROG. The core fetches through a req/ready port in RUN and gets a registered
// response one cycle later. Words not written since reset, and out-of-range
// addresses, read back as FILL_WORD.
module imem_prog #(
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          ADDR_W    = 8,
    parameter int unsigned          DEPTH     = 32,
    parameter logic [DATA_W-1:0]    FILL_WORD = '0,
    localparam int unsigned         CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              prog_en_i,
    input  logic              prog_we_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic [CNT_W-1:0]  prog_count_o,
    output logic              prog_wrap_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_ready_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              addr_err_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_W is representable and the range
    // check runs on the full fetch address, never a truncated index.
    localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PROG = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [DEPTH-1:0]    written_q, written_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic                fetch_acc;
    logic                addr_in_range;
    logic [IDX_W-1:0]    rd_idx;

    assign fetch_ready_o = (state_q == ST_RUN);
    assign fetch_acc     = fetch_req_i && fetch_ready_o;
    assign addr_in_range = ({1'b0, fetch_addr_i} < DEPTH_X);
    assign rd_idx        = fetch_addr_i[IDX_W-1:0];
    assign wr_en         = (state_q == ST_PROG) && prog_we_i && !reset_i;

    // Next-state logic for the mode FSM and the program-port bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this
        // block leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        wrap_d    = wrap_q;
        written_d = written_q;

        unique case (state_q)
            ST_RUN: begin
                if (prog_en_i) begin
                    state_d = ST_PROG;
                    wptr_d  = '0;
                    count_d = '0;
                    wrap_d  = 1'b0;
                end
            end
            ST_PROG: begin
                if (prog_we_i) begin
                    written_d[wptr_q] = 1'b1;
                    if (wptr_q == LAST_IDX) begin
                        wptr_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (!prog_en_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Fetch response: result of an accepted request, held otherwise.
    always_comb begin
        instr_d = instr_q;
        err_d   = err_q;
        valid_d = fetch_acc;
        if (fetch_acc) begin
            if (!addr_in_range) begin
                instr_d = FILL_WORD;
                err_d   = 1'b1;
            end else if (!written_q[rd_idx]) begin
                instr_d = FILL_WORD;
                err_d   = 1'b0;
            end else begin
                instr_d = mem[rd_idx];
                err_d   = 1'b0;
            end
        end
    end

    // Control and response registers; reset wins over every other input.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q   <= ST_RUN;
            wptr_q    <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            written_q <= '0;
            instr_q   <= FILL_WORD;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            written_q <= written_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Word storage written from the program port.
    always_ff @(posedge clk_i) begin
        // NOTE: the data array is deliberately not reset; the written bits
        // mask stale contents, which keeps the array mappable to plain RAM.
        if (wr_en) begin
            mem[wptr_q] <= prog_data_i;
        end
    end

    assign prog_count_o  = count_q;
    assign prog_wrap_o   = wrap_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign addr_err_o    = err_q;

endmodule
